// File: rtl/data_memory_param.sv
// data_memory_param
//    Byte-addressed little-endian data memory with byte/half/word/double
//    accesses, sign/zero extension on loads, and a power-up clear sequence
//    that zeroes every byte before requests are accepted.
//
// Ports
//    clk           rising-edge clock
//    reset         asynchronous active-high reset
//    mem_add       byte address of the access (ADDR_W bits)
//    write_data    store data, LSB-aligned
//    mem_read      load request
//    mem_write     store request
//    size          00 byte, 01 half, 10 word, 11 double
//    load_unsigned 1 zero-extends, 0 sign-extends the load result
//    read_data     registered, extended load result
//    read_valid    one-cycle pulse marking new read_data
//    ready         high while requests are accepted
//    access_err    one-cycle pulse for a misaligned or out-of-range request
//
// Configuration
//    DMEM_STORE_FWD_EN  when defined, a load issued in the same cycle as a
//                       store returns the post-store data; otherwise it
//                       returns the pre-store memory contents.
//
// State table
//    state    | meaning
//    ST_CLEAR | zeroing one byte per cycle, requests ignored
//    ST_IDLE  | accepting load/store requests
module data_memory_param #(
   parameter int DEPTH_BYTES = 512,
   parameter int ADDR_W      = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] mem_add,
   input  logic [63:0]       write_data,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        size,
   input  logic              load_unsigned,
   output logic [63:0]       read_data,
   output logic              read_valid,
   output logic              ready,
   output logic              access_err
);

   localparam int IDX_W = $clog2(DEPTH_BYTES);

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
   logic [63:0]      read_data_q;
   logic             read_valid_q;
   logic             access_err_q;

   logic [7:0]       mem_q [DEPTH_BYTES];

   logic [3:0]       nbytes;
   logic [2:0]       align_mask;
   logic [ADDR_W:0]  end_addr;
   logic             aligned;
   logic             in_range;
   logic             req_ok;
   logic             accept;
   logic             st_commit;
   logic [IDX_W-1:0] base;
   logic [63:0]      ld_raw;
   logic [63:0]      ld_ext;

   assign nbytes     = 4'd1 << size;
   // Low address bits that must be zero: none, 1, 2 or 3 bits.
   assign align_mask = {size == 2'd3, size[1], size != 2'd0};
   assign aligned    = (mem_add[2:0] & align_mask) == 3'd0;
   // One extra bit keeps mem_add + 2^size from wrapping at ADDR_W.
   assign end_addr   = {1'b0, mem_add} + (ADDR_W+1)'(nbytes);
   assign in_range   = end_addr <= (ADDR_W+1)'(DEPTH_BYTES);
   assign req_ok     = aligned & in_range;
   assign accept     = ready & (mem_read | mem_write);
   assign st_commit  = accept & mem_write & req_ok;
   assign base       = mem_add[IDX_W-1:0];

   assign ready      = (state_q == ST_IDLE);
   assign read_data  = read_data_q;
   assign read_valid = read_valid_q;
   assign access_err = access_err_q;

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      case (state_q)
         ST_CLEAR: begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == IDX_W'(DEPTH_BYTES - 1)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Gather up to eight bytes from base; bytes beyond the access size are
   // masked by the extension step. Index wrap only affects those bytes.
   always_comb begin
      ld_raw = '0;
      for (int k = 0; k < 8; k++) begin
         ld_raw[8*k +: 8] = mem_q[base + IDX_W'(k)];
`ifdef DMEM_STORE_FWD_EN
         if (st_commit && (4'(k) < nbytes)) ld_raw[8*k +: 8] = write_data[8*k +: 8];
`endif
      end
   end

   always_comb begin
      ld_ext = ld_raw;
      case (size)
         2'd0: ld_ext = load_unsigned ? {56'd0, ld_raw[7:0]}
                                      : {{56{ld_raw[7]}}, ld_raw[7:0]};
         2'd1: ld_ext = load_unsigned ? {48'd0, ld_raw[15:0]}
                                      : {{48{ld_raw[15]}}, ld_raw[15:0]};
         2'd2: ld_ext = load_unsigned ? {32'd0, ld_raw[31:0]}
                                      : {{32{ld_raw[31]}}, ld_raw[31:0]};
         default: ld_ext = ld_raw;
      endcase
   end

   // Storage has no reset; contents are zeroed only by the clear sweep.
   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR) begin
         mem_q[clr_idx_q] <= 8'h00;
      end else if (st_commit) begin
         for (int k = 0; k < 8; k++) begin
            if (4'(k) < nbytes) mem_q[base + IDX_W'(k)] <= write_data[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_CLEAR;
         clr_idx_q    <= '0;
         read_data_q  <= '0;
         read_valid_q <= 1'b0;
         access_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_idx_q    <= clr_idx_d;
         read_valid_q <= accept & mem_read;
         access_err_q <= accept & ~req_ok;
         if (accept & mem_read) read_data_q <= req_ok ? ld_ext : 64'd0;
      end
   end

endmodule

// File: tb/tb_data_memory_param.sv
module tb_data_memory_param;

   logic        clk;
   logic        reset;
   logic [63:0] mem_add;
   logic [63:0] write_data;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  size;
   logic        load_unsigned;
   logic [63:0] read_data;
   logic        read_valid;
   logic        ready;
   logic        access_err;

   int pass_cnt  = 0;
   int total_cnt = 0;

   data_memory_param #(.DEPTH_BYTES(512), .ADDR_W(64)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_add      (mem_add),
      .write_data   (write_data),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .size         (size),
      .load_unsigned(load_unsigned),
      .read_data    (read_data),
      .read_valid   (read_valid),
      .ready        (ready),
      .access_err   (access_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // One request for exactly one sampling edge; outputs are read #1 later.
   task automatic issue(input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [63:0] data, input logic [1:0] sz, input logic uns);
      mem_read      = rd;
      mem_write     = wr;
      mem_add       = addr;
      write_data    = data;
      size          = sz;
      load_unsigned = uns;
      @(posedge clk);
      #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic test_reset();
      bit bad_rdy;
      bit any_pulse;
      total_cnt++; if (ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", ready); else pass_cnt++;
      total_cnt++; if (read_valid !== 1'b0) $display("FAIL rst_read_valid: got %b want 0", read_valid); else pass_cnt++;
      total_cnt++; if (read_data !== 64'd0) $display("FAIL rst_read_data: got %h want 0", read_data); else pass_cnt++;
      total_cnt++; if (access_err !== 1'b0) $display("FAIL rst_access_err: got %b want 0", access_err); else pass_cnt++;
      reset = 1'b0;
      bad_rdy = 0;
      any_pulse = 0;
      for (int i = 1; i <= 511; i++) begin
         @(posedge clk); #1;
         if (ready !== 1'b0) bad_rdy = 1;
         if (read_valid !== 1'b0 || access_err !== 1'b0) any_pulse = 1;
      end
      total_cnt++; if (bad_rdy) $display("FAIL ready_low_511: got ready=1 before edge 512 want 0"); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (ready !== 1'b1) $display("FAIL ready_at_512: got %b want 1", ready); else pass_cnt++;
      total_cnt++; if (any_pulse) $display("FAIL clear_no_pulse: got pulse want none"); else pass_cnt++;
      issue(1, 0, 64'h100, 64'd0, 2'd2, 1'b0);
      total_cnt++; if (read_valid !== 1'b1) $display("FAIL first_load_valid: got %b want 1", read_valid); else pass_cnt++;
      total_cnt++; if (read_data !== 64'd0) $display("FAIL first_load_zero: got %h want 0", read_data); else pass_cnt++;
   endtask

   task automatic test_sign_ext();
      issue(0, 1, 64'h100, 64'h00000000_800000F0, 2'd2, 1'b0);
      total_cnt++; if (read_valid !== 1'b0) $display("FAIL store_no_valid: got %b want 0", read_valid); else pass_cnt++;
      total_cnt++; if (access_err !== 1'b0) $display("FAIL store_no_err: got %b want 0", access_err); else pass_cnt++;
      issue(1, 0, 64'h100, 64'd0, 2'd2, 1'b0);
      total_cnt++; if (read_data !== 64'hFFFFFFFF_800000F0) $display("FAIL word_signed: got %h want ffffffff800000f0", read_data); else pass_cnt++;
      issue(1, 0, 64'h100, 64'd0, 2'd2, 1'b1);
      total_cnt++; if (read_data !== 64'h00000000_800000F0) $display("FAIL word_unsigned: got %h want 00000000800000f0", read_data); else pass_cnt++;
      issue(1, 0, 64'h100, 64'd0, 2'd0, 1'b0);
      total_cnt++; if (read_data !== 64'hFFFFFFFF_FFFFFFF0) $display("FAIL byte_signed: got %h want fffffffffffffff0", read_data); else pass_cnt++;
      issue(1, 0, 64'h102, 64'd0, 2'd1, 1'b0);
      total_cnt++; if (read_data !== 64'hFFFFFFFF_FFFF8000) $display("FAIL half_signed: got %h want ffffffffffff8000", read_data); else pass_cnt++;
      issue(1, 0, 64'h102, 64'd0, 2'd1, 1'b1);
      total_cnt++; if (read_data !== 64'h00000000_00008000) $display("FAIL half_unsigned: got %h want 8000", read_data); else pass_cnt++;
      issue(1, 0, 64'h100, 64'd0, 2'd3, 1'b0);
      total_cnt++; if (read_data !== 64'h00000000_800000F0) $display("FAIL double_load: got %h want 00000000800000f0", read_data); else pass_cnt++;
   endtask

   task automatic test_byte_merge();
      issue(0, 1, 64'h100, 64'h00000000_11223344, 2'd2, 1'b0);
      issue(0, 1, 64'h103, 64'hFFFFFFFF_FFFFFFAB, 2'd0, 1'b0);
      issue(1, 0, 64'h100, 64'd0, 2'd2, 1'b1);
      total_cnt++; if (read_data !== 64'h00000000_AB223344) $display("FAIL merge_unsigned: got %h want 00000000ab223344", read_data); else pass_cnt++;
      issue(1, 0, 64'h100, 64'd0, 2'd2, 1'b0);
      total_cnt++; if (read_data !== 64'hFFFFFFFF_AB223344) $display("FAIL merge_signed: got %h want ffffffffab223344", read_data); else pass_cnt++;
      issue(1, 0, 64'h100, 64'd0, 2'd3, 1'b1);
      total_cnt++; if (read_data !== 64'h00000000_AB223344) $display("FAIL merge_double: got %h want 00000000ab223344", read_data); else pass_cnt++;
   endtask

   task automatic test_errors();
      issue(1, 0, 64'h102, 64'd0, 2'd2, 1'b1);
      total_cnt++; if (access_err !== 1'b1) $display("FAIL misalign_err: got %b want 1", access_err); else pass_cnt++;
      total_cnt++; if (read_valid !== 1'b1) $display("FAIL misalign_valid: got %b want 1", read_valid); else pass_cnt++;
      total_cnt++; if (read_data !== 64'd0) $display("FAIL misalign_data: got %h want 0", read_data); else pass_cnt++;
      issue(0, 1, 64'h1FC, 64'hFFFFFFFF_FFFFFFFF, 2'd3, 1'b0);
      total_cnt++; if (access_err !== 1'b1) $display("FAIL range_store_err: got %b want 1", access_err); else pass_cnt++;
      total_cnt++; if (read_valid !== 1'b0) $display("FAIL range_store_valid: got %b want 0", read_valid); else pass_cnt++;
      total_cnt++; if (read_data !== 64'd0) $display("FAIL range_store_data: got %h want 0", read_data); else pass_cnt++;
      issue(1, 0, 64'h100, 64'd0, 2'd2, 1'b1);
      total_cnt++; if (access_err !== 1'b0) $display("FAIL err_single_pulse: got %b want 0", access_err); else pass_cnt++;
      total_cnt++; if (read_data !== 64'h00000000_AB223344) $display("FAIL err_mem_keep: got %h want 00000000ab223344", read_data); else pass_cnt++;
      issue(1, 0, 64'h1FC, 64'd0, 2'd2, 1'b1);
      total_cnt++; if (read_data !== 64'd0) $display("FAIL err_store_suppressed: got %h want 0", read_data); else pass_cnt++;
      issue(1, 0, 64'hFFFFFFFF_FFFFFFF8, 64'd0, 2'd3, 1'b1);
      total_cnt++; if (access_err !== 1'b1) $display("FAIL overflow_addr_err: got %b want 1", access_err); else pass_cnt++;
      issue(1, 0, 64'h200, 64'd0, 2'd0, 1'b1);
      total_cnt++; if (access_err !== 1'b1) $display("FAIL past_end_err: got %b want 1", access_err); else pass_cnt++;
      issue(0, 1, 64'h1F8, 64'h88776655_44332211, 2'd3, 1'b0);
      total_cnt++; if (access_err !== 1'b0) $display("FAIL top_double_ok: got %b want 0", access_err); else pass_cnt++;
      issue(1, 0, 64'h1F8, 64'd0, 2'd3, 1'b0);
      total_cnt++; if (read_data !== 64'h88776655_44332211) $display("FAIL top_double_data: got %h want 8877665544332211", read_data); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_b [3];
      logic [63:0] addr_b [3];
      exp_b[0] = 64'h11;  addr_b[0] = 64'h1F8;
      exp_b[1] = 64'h22;  addr_b[1] = 64'h1F9;
      exp_b[2] = 64'h88;  addr_b[2] = 64'h1FF;
      mem_read = 1'b1; mem_write = 1'b0; size = 2'd0; load_unsigned = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mem_add = addr_b[i];
         @(posedge clk); #1;
         total_cnt++; if (read_valid !== 1'b1 || read_data !== exp_b[i])
            $display("FAIL b2b_load%0d: got valid=%b data=%h want valid=1 data=%h", i, read_valid, read_data, exp_b[i]);
         else pass_cnt++;
      end
      mem_read = 1'b0;
      @(posedge clk); #1;
      total_cnt++; if (read_valid !== 1'b0) $display("FAIL idle_no_valid: got %b want 0", read_valid); else pass_cnt++;
      total_cnt++; if (read_data !== 64'h88) $display("FAIL idle_hold_data: got %h want 88", read_data); else pass_cnt++;
   endtask

   task automatic test_fwd();
      logic [63:0] exp_fwd;
`ifdef DMEM_STORE_FWD_EN
      exp_fwd = 64'h55;
`else
      exp_fwd = 64'h12;
`endif
      issue(0, 1, 64'h104, 64'h12, 2'd0, 1'b1);
      issue(1, 1, 64'h104, 64'h55, 2'd0, 1'b1);
      total_cnt++; if (read_data !== exp_fwd) $display("FAIL same_cycle_load: got %h want %h", read_data, exp_fwd); else pass_cnt++;
      issue(1, 0, 64'h104, 64'd0, 2'd0, 1'b1);
      total_cnt++; if (read_data !== 64'h55) $display("FAIL same_cycle_store: got %h want 55", read_data); else pass_cnt++;
   endtask

   task automatic test_reset_midclear();
      bit bad_rdy;
      bit any_pulse;
      mem_read = 1'b1; mem_add = 64'h100; size = 2'd2; load_unsigned = 1'b1;
      @(posedge clk); #1;
      mem_read = 1'b0;
      reset = 1'b1;
      #1;
      total_cnt++; if (read_valid !== 1'b0 || read_data !== 64'd0)
         $display("FAIL async_rst_discard: got valid=%b data=%h want valid=0 data=0", read_valid, read_data);
      else pass_cnt++;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (200) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      total_cnt++; if (ready !== 1'b0) $display("FAIL midclear_rst_ready: got %b want 0", ready); else pass_cnt++;
      #1;
      reset = 1'b0;
      // Requests held during the clear must be ignored.
      mem_read = 1'b1; mem_write = 1'b1; mem_add = 64'h102; write_data = 64'hFFFF_FFFF;
      bad_rdy = 0;
      any_pulse = 0;
      for (int i = 1; i <= 511; i++) begin
         @(posedge clk); #1;
         if (ready !== 1'b0) bad_rdy = 1;
         if (read_valid !== 1'b0 || access_err !== 1'b0) any_pulse = 1;
      end
      total_cnt++; if (bad_rdy) $display("FAIL reclear_ready_low: got ready=1 early want 0"); else pass_cnt++;
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      total_cnt++; if (ready !== 1'b1) $display("FAIL reclear_ready_512: got %b want 1", ready); else pass_cnt++;
      total_cnt++; if (any_pulse || read_valid !== 1'b0) $display("FAIL reclear_ignored: got pulse want none"); else pass_cnt++;
      issue(1, 0, 64'h100, 64'd0, 2'd2, 1'b1);
      total_cnt++; if (read_data !== 64'd0) $display("FAIL reclear_zero_100: got %h want 0", read_data); else pass_cnt++;
      issue(1, 0, 64'h1F8, 64'd0, 2'd3, 1'b1);
      total_cnt++; if (read_data !== 64'd0) $display("FAIL reclear_zero_1f8: got %h want 0", read_data); else pass_cnt++;
   endtask

   initial begin
      reset         = 1'b1;
      mem_add       = '0;
      write_data    = '0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      size          = 2'd0;
      load_unsigned = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_sign_ext();
      test_byte_merge();
      test_errors();
      test_back_to_back();
      test_fwd();
      test_reset_midclear();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/data_memory_param.md
DATA_MEMORY_PARAM -- requirements
Module: data_memory_param

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DEPTH_BYTES, default 512: memory size in bytes, power of two, minimum 64.
REQ-003 Parameter ADDR_W, default 64: width of mem_add.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 mem_add  input  ADDR_W  byte address of the access.
REQ-007 write_data  input  64  store data, LSB-aligned.
REQ-008 mem_read  input  1  load request, sampled at rising clk.
REQ-009 mem_write  input  1  store request, sampled at rising clk.
REQ-010 size  input  2  access size: 00 byte, 01 half, 10 word, 11 double.
REQ-011 load_unsigned  input  1  1 selects zero-extension, 0 selects sign-extension.
REQ-012 read_data  output  64  registered, extended load result.
REQ-013 read_valid  output  1  one-cycle pulse marking new read_data.
REQ-014 ready  output  1  high when requests are accepted.
REQ-015 access_err  output  1  one-cycle pulse for a misaligned or out-of-range request.

Function
REQ-016 Storage SHALL be little-endian: byte k of a datum is at mem_add+k.
REQ-017 FSM states SHALL be CLEAR and IDLE; reset forces CLEAR with clear index 0.
REQ-018 CLEAR SHALL write 0 to one byte per cycle, index 0 to DEPTH_BYTES-1, then enter IDLE; ready=0 throughout CLEAR.
REQ-019 ready SHALL be 1 exactly DEPTH_BYTES rising edges after reset deasserts, and 1 in every IDLE cycle.
REQ-020 Requests sampled while ready=0 SHALL be ignored: no write, no read_valid, no access_err.
REQ-021 An accepted request SHALL be aligned: mem_add is a multiple of 2^size.
REQ-022 An accepted request SHALL be in range: mem_add+2^size <= DEPTH_BYTES, computed without ADDR_W overflow.
REQ-023 A misaligned or out-of-range request SHALL do all of: suppress the store, pulse access_err in the next cycle, pulse read_valid if mem_read=1, and drive read_data=0.
REQ-024 A store SHALL commit 2^size bytes from write_data[8*2^size-1:0] at the sampling edge; all other bytes are unchanged.
REQ-025 A load SHALL have one-cycle latency: a request sampled at edge N updates read_data and pulses read_valid after edge N.
REQ-026 Load data SHALL be the 2^size bytes extended to 64 bits per load_unsigned; size 11 ignores load_unsigned.
REQ-027 read_data SHALL hold its last value until the next accepted load.
REQ-028 When mem_read and mem_write are both 1 in the same cycle, the store SHALL commit, and the load result SHALL follow REQ-034/REQ-035.
REQ-029 Back-to-back loads SHALL be accepted every cycle, with read_valid high continuously.

Reset
REQ-030 On reset assertion, read_data=0, read_valid=0, access_err=0, ready=0, state=CLEAR, clear index=0, all immediately (asynchronous).
REQ-031 Reset asserted mid-CLEAR or mid-operation SHALL restart CLEAR from index 0; in-flight load results SHALL be discarded.
REQ-032 Memory contents SHALL NOT be required to change on reset assertion itself; zeroing occurs only via CLEAR.

Configuration
REQ-033 Macro DMEM_STORE_FWD_EN SHALL select same-cycle store-to-load forwarding.
REQ-034 With DMEM_STORE_FWD_EN defined, a simultaneous load returns post-store data: overlapping bytes come from write_data, other bytes from memory.
REQ-035 Without DMEM_STORE_FWD_EN, a simultaneous load SHALL return pre-store memory contents.

Verification
REQ-036 Release reset; count edges -> ready=0 for 511 edges and ready=1 at edge 512; a read of 0x100, size 10, returns 0.
REQ-037 Store 0x00000000_8000_00F0 at 0x100, size 10; load 0x100 size 10 signed -> 0xFFFFFFFF_800000F0; unsigned -> 0x00000000_800000F0.
REQ-038 Store 0xAB at 0x103, size 00, over word 0x11223344 at 0x100 -> word load returns 0x00000000_AB223344.
REQ-039 Load at 0x102, size 10, then store at 0x1FC, size 11 -> access_err pulses twice, read_data=0, and memory is unchanged.
REQ-040 Same-cycle store 0x55 and load at 0x104, size 00, with prior byte 0x12 -> 0x55 with DMEM_STORE_FWD_EN defined, else 0x12.
REQ-041 Assert reset during cycle 200 of CLEAR, then release -> ready rises after 512 further edges and no read_valid occurs meanwhile.
